alu_issue_ctrl: RTL and testbench

Sequential issue controller that drives the combinational 32-bit ALU from the other side of its opcode/operand/result interface. It accepts encoded instruction words over a valid/ready handshake and decodes them. It reads operands from a local 8-entry register file, presents opcode and operands to the ALU, and writes the ALU result back. The block sits between the instruction source and the ALU in the CPU datapath. The ALU is instantiated alongside it at the top level.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, controller states,
// instruction field positions and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam int OPC_LSB     = 28;
    localparam int RD_LSB      = 25;
    localparam int RS1_LSB     = 22;
    localparam int RS2_LSB     = 19;
    localparam int IMM_SEL_BIT = 18;
    localparam int RSVD_LSB    = 16;
    localparam int IMM_LSB     = 0;
    localparam int IMM_W       = 16;

    function automatic logic is_legal_opcode(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SRL, OP_SLL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue controller: two operand read ports, a debug
// read port and one write port; R0 always reads zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
        rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts instruction words, reads operands, drives the
// external ALU and writes its result back into the local register file.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] dbg_rd_addr,
    output logic [DATA_W-1:0] dbg_rd_data
);

    state_t             state;
    logic [3:0]         opc_q;
    logic [ADDR_W-1:0]  rd_q;
    logic [ADDR_W-1:0]  rs1_q;
    logic [ADDR_W-1:0]  rs2_q;
    logic               imm_sel_q;
    logic [IMM_W-1:0]   imm_q;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic [DATA_W-1:0]  imm_ext;
    logic               rsvd_unused;

    assign rsvd_unused = ^instr[RSVD_LSB +: 2];
    assign instr_ready = (state == IDLE);
    assign imm_ext     = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

    // Writeback shares the EXEC closing edge with the wb_addr/wb_data update,
    // so a reset during EXEC cancels both together.
    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1   (rs1_q),
        .rdata1   (rs1_data),
        .raddr2   (rs2_q),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_rd_addr),
        .dbg_data (dbg_rd_data),
        .we       (state == EXEC),
        .waddr    (rd_q),
        .wdata    (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            opc_q        <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_sel_q    <= 1'b0;
            imm_q        <= '0;
            alu_opcode   <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
        end else begin
            done        <= 1'b0;
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        opc_q     <= instr[OPC_LSB +: 4];
                        rd_q      <= instr[RD_LSB +: ADDR_W];
                        rs1_q     <= instr[RS1_LSB +: ADDR_W];
                        rs2_q     <= instr[RS2_LSB +: ADDR_W];
                        imm_sel_q <= instr[IMM_SEL_BIT];
                        imm_q     <= instr[IMM_LSB +: IMM_W];
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (!is_legal_opcode(opc_q)) begin
                        err_illegal <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        alu_opcode   <= opc_q;
                        alu_operand1 <= rs1_data;
                        alu_operand2 <= imm_sel_q ? imm_ext : rs2_data;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    wb_addr <= rd_q;
                    wb_data <= alu_result;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl; the bench plays the ALU and keeps its
// own register model to predict every writeback and illegal-opcode pulse.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [31:0]       instr = '0;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_operand2;
    logic [DATA_W-1:0] alu_result;
    logic              done;
    logic              err_illegal;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] dbg_rd_addr = '0;
    logic [DATA_W-1:0] dbg_rd_data;

    typedef struct {
        bit          is_err;
        logic [2:0]  rd;
        logic [31:0] data;
        logic [3:0]  opc;
        logic [31:0] op1;
        logic [31:0] op2;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mregs [NREGS];
    logic [3:0]  last_opc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .done         (done),
        .err_illegal  (err_illegal),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .dbg_rd_addr  (dbg_rd_addr),
        .dbg_rd_data  (dbg_rd_data)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a * b;
            4'b0011: return a & b;
            4'b0100: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return ~a;
            4'b1000: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
            4'b1001: return (b >= 32) ? 32'd0 : (a << b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_opcode, alu_operand1, alu_operand2);

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic isel, input logic [15:0] imm);
        return {op, rd, rs1, rs2, isel, 2'b00, imm};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every done/err_illegal pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done || err_illegal) begin
                check_eq("pulse_exclusive", {31'd0, done & err_illegal}, 32'd0);
                if (sbq.size() == 0) begin
                    check_eq("spurious_pulse", {30'd0, done, err_illegal}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check_eq("pulse_kind_err", {31'd0, err_illegal}, {31'd0, e.is_err});
                    check_eq("pulse_latency", cyc - e.acc, e.is_err ? 32'd2 : 32'd3);
                    check_eq("ready_at_pulse", {31'd0, instr_ready}, 32'd1);
                    if (e.is_err) begin
                        check_eq("alu_opcode_held", {28'd0, alu_opcode}, {28'd0, e.opc});
                    end else begin
                        check_eq("wb_addr", {29'd0, wb_addr}, {29'd0, e.rd});
                        check_eq("wb_data", wb_data, e.data);
                    end
                end
            end else if (sbq.size() > 0) begin
                e = sbq[0];
                if (!e.is_err && cyc == e.acc + 2) begin
                    check_eq("exec_opcode", {28'd0, alu_opcode}, {28'd0, e.opc});
                    check_eq("exec_operand1", alu_operand1, e.op1);
                    check_eq("exec_operand2", alu_operand2, e.op2);
                end
                if (cyc > e.acc + 3) begin
                    check_eq("pulse_missing", {31'd0, done | err_illegal}, 32'd1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [31:0] w);
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = w;
        for (int n = 0; n < 20 && !instr_ready; n++) @(negedge clk);
        if (!instr_ready) begin
            check_eq("accept_timeout", {31'd0, instr_ready}, 32'd1);
            return;
        end
        op       = w[31:28];
        e.acc    = cyc;
        e.rd     = w[27:25];
        e.op1    = 32'd0;
        e.op2    = 32'd0;
        e.data   = 32'd0;
        if (op == 4'b0101 || op >= 4'b1010) begin
            e.is_err = 1'b1;
            e.opc    = last_opc;
        end else begin
            e.is_err = 1'b0;
            e.opc    = op;
            a = mregs[w[24:22]];
            b = w[18] ? {{16{w[15]}}, w[15:0]} : mregs[w[21:19]];
            e.op1  = a;
            e.op2  = b;
            e.data = alu_ref(op, a, b);
            if (w[27:25] != 3'd0) mregs[w[27:25]] = e.data;
            last_opc = op;
        end
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        instr_valid = 1'b0;
        for (int n = 0; n < 20 && sbq.size() > 0; n++) @(negedge clk);
        check_eq("scoreboard_drained", sbq.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic read_reg(input int a, output logic [31:0] d);
        @(negedge clk);
        dbg_rd_addr = a[2:0];
        #1;
        d = dbg_rd_data;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        for (int i = 0; i < NREGS; i++) begin
            read_reg(i, d);
            check_eq($sformatf("%s_r%0d", tag, i), d, mregs[i]);
        end
    endtask

    task automatic check_const(input int a, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(a, d);
        check_eq($sformatf("const_r%0d", a), d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'd0;

        repeat (3) @(negedge clk);
        check_eq("ready_in_reset", {31'd0, instr_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_opcode", {28'd0, alu_opcode}, 32'd0);
        check_eq("rst_operand1", alu_operand1, 32'd0);
        check_eq("rst_operand2", alu_operand2, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err_illegal}, 32'd0);
        check_eq("rst_wb_addr", {29'd0, wb_addr}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_regs("rst");

        // add r1 = r0 + 25, then r2 = r1 + r1 with valid held high
        issue(enc(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd25));
        issue(enc(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0));
        issue(enc(OP_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0));
        issue(enc(OP_MUL, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0));
        issue(enc(OP_NOT, 3'd5, 3'd1, 3'd0, 1'b0, 16'd0));
        drain();
        check_const(1, 32'd25);
        check_const(2, 32'd50);
        check_const(3, 32'hFFFF_FFE7);
        check_const(4, 32'd625);
        check_const(5, 32'hFFFF_FFE6);

        issue(enc(4'b0101, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0));
        issue(enc(4'b1111, 3'd2, 3'd1, 3'd1, 1'b1, 16'd7));
        drain();
        check_regs("after_illegal");
        check_eq("opcode_after_illegal", {28'd0, alu_opcode}, {28'd0, OP_NOT});

        issue(enc(OP_AND, 3'd6, 3'd5, 3'd3, 1'b0, 16'd0));
        issue(enc(OP_OR,  3'd6, 3'd6, 3'd0, 1'b1, 16'h0101));
        issue(enc(OP_XOR, 3'd6, 3'd3, 3'd5, 1'b0, 16'd0));
        issue(enc(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF));
        drain();
        check_const(6, 32'hFFFF_FFFF);
        issue(enc(OP_SLL, 3'd6, 3'd1, 3'd0, 1'b1, 16'd32));
        issue(enc(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'd1));
        issue(enc(OP_SLL, 3'd7, 3'd7, 3'd0, 1'b1, 16'd31));
        drain();
        check_const(6, 32'd0);
        check_const(7, 32'h8000_0000);
        issue(enc(OP_SRL, 3'd7, 3'd7, 3'd0, 1'b1, 16'd31));
        issue(enc(OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 16'd5));
        drain();
        check_const(7, 32'd1);
        check_const(0, 32'd0);
        check_regs("after_shift");

        // Reset asserted while add r1 = r1 + 1 is in EXEC
        issue(enc(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 16'd1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        sbq.delete();
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'd0;
        last_opc = '0;
        #1;
        check_eq("midop_rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("midop_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_eq("done_after_rst", {31'd0, done}, 32'd0);
        end
        check_eq("wb_data_after_rst", wb_data, 32'd0);
        check_regs("after_rst");
        check_const(1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
